// File: rtl/fatori_err_collector.sv
// fatori_err_collector: edge-counts M-of-N monitor errors, escalates minor/major alerts, clear handshake.
module fatori_err_collector #(
  parameter int NUM_MON    = 4,
  parameter int CNT_W      = 8,
  parameter int MIN_THRESH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_MON-1:0]       min_err_i,
  input  logic [NUM_MON-1:0]       maj_err_i,
  input  logic                     clr_req_i,
  output logic                     clr_ack_o,
  input  logic [$clog2(NUM_MON):0] rd_sel_i,
  output logic [CNT_W-1:0]         rd_cnt_o,
  output logic                     alert_minor_o,
  output logic                     alert_major_o,
  output logic [NUM_MON-1:0]       maj_src_o,
  output logic [1:0]               state_o
);
  localparam int TW = CNT_W + 4;
  localparam int SW = $clog2(NUM_MON) + 1;
  localparam int IW = NUM_MON > 1 ? $clog2(NUM_MON) : 1;
  localparam logic [SW-1:0] NM = SW'(NUM_MON);
  localparam logic [TW-1:0] TH = TW'(MIN_THRESH);
  typedef enum logic [1:0] {OK = 2'd0, MINOR = 2'd1, MAJOR = 2'd2, CLEAR = 2'd3} state_t;
  state_t              state_q, state_d;
  logic [NUM_MON-1:0]  min_q, maj_q, min_e, maj_e, maj_src_q, maj_src_d;
  logic [CNT_W-1:0]    cnt_q [NUM_MON];
  logic [CNT_W-1:0]    cnt_d [NUM_MON];
  logic [TW-1:0]       tot_q, tot_d;
  logic [TW:0]         sum;
  logic [CNT_W-1:0]    rd_q;
  logic                clr, go_clr, blk_q, ack_q, alert_q;
  always_comb begin
    min_e  = min_err_i & ~min_q;
    maj_e  = maj_err_i & ~maj_q;
    clr    = state_q == CLEAR;
    go_clr = !clr && clr_req_i && !blk_q;
    sum    = clr ? '0 : {1'b0, tot_q};
    for (int k = 0; k < NUM_MON; k++) begin
      sum      = sum + (TW+1)'(min_e[k]);
      cnt_d[k] = clr ? CNT_W'(min_e[k]) : cnt_q[k] + CNT_W'(min_e[k] && cnt_q[k] != '1);
    end
    tot_d     = sum[TW] ? '1 : sum[TW-1:0];
    maj_src_d = (clr ? '0 : maj_src_q) | maj_e;
    // clear wins over everything; major outranks minor and both are sticky until cleared
    state_d   = clr ? OK :
                go_clr ? CLEAR :
                (state_q == MAJOR || |maj_src_q) ? MAJOR :
                (state_q == MINOR || tot_q >= TH) ? MINOR : OK;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= OK;
      min_q     <= '0;
      maj_q     <= '0;
      maj_src_q <= '0;
      cnt_q     <= '{default: '0};
      tot_q     <= '0;
      blk_q     <= 1'b0;
      ack_q     <= 1'b0;
      alert_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_err_i;
      maj_q     <= maj_err_i;
      maj_src_q <= maj_src_d;
      cnt_q     <= cnt_d;
      tot_q     <= tot_d;
      blk_q     <= clr_req_i && (blk_q || clr);
      ack_q     <= go_clr;
      alert_q   <= !go_clr && tot_d >= TH;
      rd_q      <= rd_sel_i < NM ? cnt_q[rd_sel_i[IW-1:0]] : '0;
    end
  end
  assign clr_ack_o     = ack_q;
  assign rd_cnt_o      = rd_q;
  assign alert_minor_o = alert_q;
  assign alert_major_o = |maj_src_q;
  assign maj_src_o     = maj_src_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_fatori_err_collector.sv
// tb_fatori_err_collector: directed + random checks against an event-counting reference model.
module tb_fatori_err_collector;
  logic       clk = 0, rst = 1, clr_req = 0, ack, a_min, a_maj;
  logic [3:0] min_err = 0, maj_err = 0, maj_src;
  logic [2:0] rd_sel = 0;
  logic [7:0] rd_cnt;
  logic [1:0] st;
  logic       s_ack, s_min_a, s_maj_a;
  logic [3:0] s_min = 0, s_maj_src;
  logic [2:0] s_sel = 0;
  logic [1:0] s_cnt, s_st;
  int n_tests = 0, n_fail = 0;
  int cnt_m [4];
  int tot_m;
  logic [3:0] maj_m, pmin, pmaj, cur_min;
  bit minor_seen, clr_cycle;
  always #5 clk = ~clk;
  fatori_err_collector u_dut (
    .clk_i(clk), .rst_i(rst), .min_err_i(min_err), .maj_err_i(maj_err), .clr_req_i(clr_req),
    .clr_ack_o(ack), .rd_sel_i(rd_sel), .rd_cnt_o(rd_cnt), .alert_minor_o(a_min),
    .alert_major_o(a_maj), .maj_src_o(maj_src), .state_o(st));
  fatori_err_collector #(.NUM_MON(4), .CNT_W(2), .MIN_THRESH(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .min_err_i(s_min), .maj_err_i(4'b0), .clr_req_i(1'b0),
    .clr_ack_o(s_ack), .rd_sel_i(s_sel), .rd_cnt_o(s_cnt), .alert_minor_o(s_min_a),
    .alert_major_o(s_maj_a), .maj_src_o(s_maj_src), .state_o(s_st));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (cnt_m[k]) cnt_m[k] = 0;
    tot_m = 0; maj_m = 0; pmin = 0; pmaj = 0; cur_min = 0; minor_seen = 0; clr_cycle = 0;
  endtask
  task automatic step(input logic [3:0] mn, input logic [3:0] mj);
    logic [3:0] e;
    min_err = mn; maj_err = mj; cur_min = mn;
    @(posedge clk);
    e = mn & ~pmin;
    if (clr_cycle) begin
      foreach (cnt_m[k]) cnt_m[k] = 0;
      tot_m = 0; maj_m = 0; minor_seen = 0; clr_cycle = 0;
    end
    foreach (cnt_m[k]) if (e[k] && cnt_m[k] < 255) cnt_m[k]++;
    tot_m = tot_m + $countones(e);
    if (tot_m > 4095) tot_m = 4095;
    maj_m = maj_m | (mj & ~pmaj);
    pmin = mn; pmaj = mj;
    if (tot_m >= 16) minor_seen = 1;
    #1;
  endtask
  task automatic settle();
    repeat (2) step(cur_min, 4'b0);
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_alert_minor"}, 32'(a_min), 32'(tot_m >= 16));
    chk({tag, "_alert_major"}, 32'(a_maj), 32'(maj_m != 0));
    chk({tag, "_maj_src"}, 32'(maj_src), 32'(maj_m));
    chk({tag, "_state"}, 32'(st), maj_m != 0 ? 2 : minor_seen ? 1 : 0);
  endtask
  task automatic read_all(input string tag);
    for (int s = 0; s < 4; s++) begin
      rd_sel = 3'(s);
      step(cur_min, 4'b0);
      chk($sformatf("%s_rd%0d", tag, s), 32'(rd_cnt), 32'(cnt_m[s]));
    end
  endtask
  task automatic do_clear(input string tag, input logic [3:0] mn_in_clear);
    clr_req = 1;
    step(cur_min, 4'b0);
    chk({tag, "_ack"}, 32'(ack), 1);
    chk({tag, "_state_clear"}, 32'(st), 3);
    clr_cycle = 1;
    step(mn_in_clear, 4'b0);
    chk({tag, "_ack_one_pulse"}, 32'(ack), 0);
    chk({tag, "_state_ok"}, 32'(st), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] one;
    one = 4'b0001;
    model_reset();
    min_err = '1; maj_err = '1; clr_req = 1; rd_sel = '1; s_min = '1; s_sel = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rd_cnt", 32'(rd_cnt), 0);
    chk("rst_alert_minor", 32'(a_min), 0);
    chk("rst_alert_major", 32'(a_maj), 0);
    chk("rst_maj_src", 32'(maj_src), 0);
    chk("rst_state", 32'(st), 0);
    chk("rst_sat_outputs", {s_ack, s_min_a, s_maj_a, s_maj_src, s_cnt, s_st}, 0);
    min_err = 0; maj_err = 0; clr_req = 0; rd_sel = 0; s_min = 0; s_sel = 0; rst = 0;
    repeat (5) step(4'b0100, 4'b0);
    step(4'b0, 4'b0);
    settle();
    rd_sel = 2;
    step(4'b0, 4'b0);
    chk("hold_rd_cnt2", 32'(rd_cnt), 1);
    check_state("hold");
    step(4'b0011, 4'b0);
    step(4'b0, 4'b0);
    settle();
    read_all("dual");
    check_state("dual");
    while (tot_m < 15) begin
      step(one << $urandom_range(0, 3), 4'b0);
      step(4'b0, 4'b0);
    end
    settle();
    check_state("below_thresh");
    step(one << $urandom_range(0, 3), 4'b0);
    step(4'b0, 4'b0);
    settle();
    check_state("at_thresh");
    read_all("thresh");
    rd_sel = 4;
    step(4'b0, 4'b0);
    chk("rd_oor4", 32'(rd_cnt), 0);
    rd_sel = 7;
    step(4'b0, 4'b0);
    chk("rd_oor7", 32'(rd_cnt), 0);
    step(4'b0, 4'b1000);
    chk("maj_src_next", 32'(maj_src), 32'h8);
    chk("maj_alert_next", 32'(a_maj), 1);
    step(4'b0, 4'b0);
    settle();
    check_state("major");
    do_clear("race", 4'b0001);
    repeat (3) begin
      step(cur_min, 4'b0);
      chk("race_no_reack", 32'(ack), 0);
    end
    read_all("race");
    check_state("race");
    clr_req = 0;
    step(4'b0, 4'b0);
    do_clear("reclear", 4'b0);
    clr_req = 0;
    settle();
    read_all("reclear");
    repeat (40) step(4'($urandom_range(0, 15)), 4'b0);
    step(4'b0, 4'b0);
    settle();
    read_all("rand");
    check_state("rand");
    min_err = 0;
    clr_req = 1; rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    chk("abort_ack", 32'(ack), 0);
    chk("abort_state", 32'(st), 0);
    rst = 0; clr_req = 0;
    step(4'b0, 4'b0);
    chk("abort_ack_after", 32'(ack), 0);
    check_state("abort");
    repeat (5) begin
      s_min = 4'b0010;
      @(posedge clk);
      s_min = 4'b0;
      @(posedge clk);
    end
    s_sel = 1;
    @(posedge clk);
    #1;
    chk("sat_rd_cnt1", 32'(s_cnt), 3);
    chk("sat_alert_minor", 32'(s_min_a), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
